// File: rtl/instr_memory_loader_if.sv
// rtl/instr_memory_loader_if.sv - CPU fetch port plus byte-serial program load stream.
interface instr_memory_loader_if #(
  parameter int DEPTH_WORDS = 64
);
  logic [31:0]                    instr_address;
  logic [31:0]                    instr_readdata;
  logic                           load_valid;
  logic [7:0]                     load_byte;
  logic                           load_last;
  logic                           load_ready;
  logic                           load_done;
  logic                           load_error;
  logic [$clog2(DEPTH_WORDS):0]   words_loaded;

  modport master (
    output instr_address, load_valid, load_byte, load_last,
    input  instr_readdata, load_ready, load_done, load_error, words_loaded
  );

  modport slave (
    input  instr_address, load_valid, load_byte, load_last,
    output instr_readdata, load_ready, load_done, load_error, words_loaded
  );
endinterface

// File: rtl/instr_memory_loader.sv
// rtl/instr_memory_loader.sv - run-time loadable instruction memory with combinational fetch.
module instr_memory_loader #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          DEPTH_WORDS = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clk_enable,
  instr_memory_loader_if.slave  bus
);
  localparam int          AW   = $clog2(DEPTH_WORDS);
  localparam int          CW   = AW + 1;
  localparam logic [31:0] SPAN = 32'(4 * DEPTH_WORDS);

  typedef enum logic [1:0] {S_LOAD, S_DONE, S_ERROR} state_t;

  state_t          state_q;
  logic [1:0]      idx_q;
  logic [31:0]     asm_q;
  logic [CW-1:0]   wl_q;
  logic            ready_q;
  logic            done_q;
  logic            error_q;
  logic [31:0]     mem [DEPTH_WORDS];

  logic            accept;
  logic            full;
  logic            commit;
  logic [31:0]     word_d;
  logic [31:0]     offset;
  logic [AW-1:0]   rd_index;
  logic            hit;

  assign accept = bus.load_valid & ready_q & clk_enable;
  assign full   = (wl_q == CW'(DEPTH_WORDS));
  // Big-endian: byte k lands at bits [31-8k : 24-8k]; unreceived bytes stay zero.
  assign word_d = asm_q | (32'(bus.load_byte) << (5'd24 - {idx_q, 3'b000}));
  assign commit = accept & (state_q == S_LOAD) & ~full
                & ((idx_q == 2'd3) | bus.load_last);

  always_ff @(posedge clk) begin
    if (commit) begin
      mem[wl_q[AW-1:0]] <= word_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_LOAD;
      idx_q   <= 2'd0;
      asm_q   <= 32'd0;
      wl_q    <= '0;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else if (accept) begin
      if (full) begin
        // Overflowing byte is swallowed; memory is left intact.
        state_q <= S_ERROR;
        ready_q <= 1'b0;
        error_q <= 1'b1;
      end else if (commit) begin
        wl_q  <= wl_q + 1'b1;
        idx_q <= 2'd0;
        asm_q <= 32'd0;
        if (bus.load_last) begin
          state_q <= S_DONE;
          ready_q <= 1'b0;
          done_q  <= 1'b1;
        end
      end else begin
        asm_q <= word_d;
        idx_q <= idx_q + 2'd1;
      end
    end
  end

  // Underflowed subtraction is rejected by the >= BASE_ADDR term.
  assign offset   = bus.instr_address - BASE_ADDR;
  assign rd_index = offset[AW+1:2];
  assign hit      = (bus.instr_address >= BASE_ADDR) && (offset < SPAN)
                 && (bus.instr_address[1:0] == 2'b00)
                 && ({1'b0, rd_index} < wl_q);

  assign bus.instr_readdata = hit ? mem[rd_index] : 32'h00000000;
  assign bus.load_ready     = ready_q;
  assign bus.load_done      = done_q;
  assign bus.load_error     = error_q;
  assign bus.words_loaded   = wl_q;
endmodule
